// File: rtl/range_filter_pkg.sv
// Shared types and elaboration-time helpers for the range smoothing filter.
package range_filter_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS    = 2'd0,
    MODE_BINOM     = 2'd1,
    MODE_CLAMP     = 2'd2,
    MODE_BINOM_ALT = 2'd3
  } mode_e;

  // C(n, k) built incrementally; every intermediate quotient is exact.
  function automatic int binom_coef(input int n, input int k);
    int c;
    c = 1;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  // The weights sum to 2^(taps-1), so this width can never overflow.
  function automatic int acc_width(input int dw, input int taps);
    return dw + taps - 1;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider: tick is high for one clock every PERIOD clocks.
module sample_tick_gen #(
  parameter int PERIOD = 12_500_000
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(PERIOD - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/range_filter_core.sv
// Tick-sampled binomial smoothing filter with bypass and spike-limiting modes.
module range_filter_core
  import range_filter_pkg::*;
#(
  parameter int DW            = 19,
  parameter int TAPS          = 5,
  parameter int SAMPLE_PERIOD = 12_500_000,
  parameter int MAX_STEP      = 2000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] data_in,
  input  logic [1:0]    mode,
  output logic [DW-1:0] data_out,
  output logic          flag_out,
  output logic          filled
);

  localparam int ACC_W = acc_width(DW, TAPS);
  localparam int FW    = $clog2(TAPS + 1);
  localparam logic [DW:0] STEP = (DW + 1)'(MAX_STEP);
  localparam logic [DW:0] MAXV = {1'b0, {DW{1'b1}}};

  if (!(TAPS == 1 || TAPS == 3 || TAPS == 5 || TAPS == 7)) begin : g_bad_taps
    $fatal(1, "range_filter_core: TAPS must be 1, 3, 5 or 7");
  end
  if (SAMPLE_PERIOD < 4) begin : g_bad_period
    $fatal(1, "range_filter_core: SAMPLE_PERIOD must be at least 4");
  end
  if (longint'(MAX_STEP) >= (longint'(1) << DW)) begin : g_bad_step
    $fatal(1, "range_filter_core: MAX_STEP must be below 2^DW");
  end

  logic            tick;
  logic [DW-1:0]   win [TAPS];
  logic [FW-1:0]   fill_cnt;
  logic            s0_vld;
  mode_e           mode_q;
  logic            first_out;
  logic [DW-1:0]   x_clamped;
  logic [DW:0]     x_ext, ref_ext, hi_lim, lo_sum;
  logic [ACC_W-1:0] acc;
  logic            s1_en;
  logic [DW-1:0]   s1_val;

  sample_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  assign filled = (fill_cnt == FW'(TAPS));

  // Step limit against the last published result, evaluated in DW+1 bits.
  always_comb begin
    x_ext     = {1'b0, data_in};
    ref_ext   = {1'b0, data_out};
    hi_lim    = ref_ext + STEP;
    lo_sum    = x_ext + STEP;
    x_clamped = data_in;
    if (mode == MODE_CLAMP && first_out) begin
      if (x_ext > hi_lim) x_clamped = (hi_lim > MAXV) ? '1 : hi_lim[DW-1:0];
      else if (lo_sum < ref_ext) x_clamped = DW'(ref_ext - STEP);
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < TAPS; i++)
      acc = acc + ACC_W'(binom_coef(TAPS - 1, i)) * ACC_W'(win[i]);
  end

  // Stage 0: window shift, warm-up count and mode capture on the tick edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) win[i] <= '0;
      fill_cnt <= '0;
      s0_vld   <= 1'b0;
      mode_q   <= MODE_BYPASS;
    end else begin
      s0_vld <= tick;
      if (tick) begin
        win[0] <= x_clamped;
        for (int i = 1; i < TAPS; i++) win[i] <= win[i-1];
        if (fill_cnt != FW'(TAPS)) fill_cnt <= fill_cnt + FW'(1);
        mode_q <= mode_e'(mode);
      end
    end
  end

  // Stage 1: in bypass the newest window entry is the unmodified sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_en  <= 1'b0;
      s1_val <= '0;
    end else begin
      s1_en  <= s0_vld && (mode_q == MODE_BYPASS || filled);
      s1_val <= (mode_q == MODE_BYPASS) ? win[0] : DW'(acc >> (TAPS - 1));
    end
  end

  // Stage 2: flag_out is a valid-only strobe with no ready; data_out is held
  // until the next accepted result, so a consumer may sample it at leisure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out  <= '0;
      flag_out  <= 1'b0;
      first_out <= 1'b0;
    end else begin
      flag_out <= s1_en;
      if (s1_en) begin
        data_out  <= s1_val;
        first_out <= 1'b1;
      end
    end
  end

endmodule
